// File: rtl/glitch_sweep_pkg.sv
// Shared types and default widths for the glitch parameter sweep controller.
package glitch_sweep_pkg;
  localparam int W_DEF  = 32;
  localparam int AW_DEF = 16;

  typedef enum logic [2:0] {IDLE, RST_GL, ARM, SETTLE, STEP, DONE} state_e;
endpackage

// File: rtl/sweep_timer.sv
// Loadable up-counter with an equality flag; one instance times both the arm
// timeout and the settle window.
module sweep_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] match_val,
  output logic         match
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)    cnt_d = load_val;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign match = (cnt_q == match_val);
endmodule

// File: rtl/glitch_sweep_ctrl.sv
// Sweeps a (delay, width) grid, arming the glitch engine a configurable number
// of times per point and stopping at the first observed target success.
module glitch_sweep_ctrl import glitch_sweep_pkg::*; #(
  parameter int W  = W_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  delay_min,
  input  logic [W-1:0]  delay_max,
  input  logic [W-1:0]  delay_step,
  input  logic [W-1:0]  width_min,
  input  logic [W-1:0]  width_max,
  input  logic [W-1:0]  width_step,
  input  logic [AW-1:0] attempts,
  input  logic [W-1:0]  settle_cycles,
  input  logic [W-1:0]  timeout_cycles,
  input  logic          glitch_finished,
  input  logic          success_in,
  output logic [W-1:0]  glitch_delay,
  output logic [W-1:0]  glitch_width,
  output logic          arm,
  output logic          reset_glitcher,
  output logic          busy,
  output logic          done,
  output logic          hit,
  output logic [W-1:0]  hit_delay,
  output logic [W-1:0]  hit_width,
  output logic [W-1:0]  attempt_count
);
  state_e        state_q, state_d;
  logic [W-1:0]  dmax_q, dmax_d, dstep_q, dstep_d;
  logic [W-1:0]  wmin_q, wmin_d, wmax_q, wmax_d, wstep_q, wstep_d;
  logic [W-1:0]  settle_q, settle_d, tmo_q, tmo_d;
  logic [AW-1:0] att_q, att_d, pp_q, pp_d;
  logic [W-1:0]  delay_q, delay_d, width_q, width_d;
  logic [W-1:0]  hd_q, hd_d, hw_q, hw_d, acnt_q, acnt_d;
  logic          hit_q, hit_d, arm_q, arm_d, rg_q, rg_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic          tmr_load, tmr_en, tmr_match;
  logic [W-1:0]  tmr_mval, settle_eff, acnt_inc;
  logic [AW-1:0] att_eff;
  logic [AW:0]   pp_nxt;
  logic [W:0]    wsum, dsum;
  logic          w_wrap, d_end;

  // Sums are one bit wider so a wrap past 2^W counts as "beyond max".
  assign wsum       = {1'b0, width_q} + {1'b0, wstep_q};
  assign dsum       = {1'b0, delay_q} + {1'b0, dstep_q};
  assign w_wrap     = (wstep_q == '0) || (wsum > {1'b0, wmax_q});
  assign d_end      = (dstep_q == '0) || (dsum > {1'b0, dmax_q});
  assign att_eff    = (att_q == '0) ? AW'(1) : att_q;
  assign pp_nxt     = {1'b0, pp_q} + (AW+1)'(1);
  assign settle_eff = (settle_q == '0) ? W'(1) : settle_q;
  assign acnt_inc   = (acnt_q == '1) ? acnt_q : acnt_q + W'(1);
  assign tmr_mval   = (state_q == SETTLE) ? settle_eff : tmo_q;

  sweep_timer #(.W(W)) u_timer (
    .clk(clk), .rst(rst), .load(tmr_load), .en(tmr_en),
    .load_val(W'(1)), .match_val(tmr_mval), .match(tmr_match)
  );

  always_comb begin
    state_d = state_q;
    dmax_d = dmax_q; dstep_d = dstep_q;
    wmin_d = wmin_q; wmax_d = wmax_q; wstep_d = wstep_q;
    settle_d = settle_q; tmo_d = tmo_q; att_d = att_q; pp_d = pp_q;
    delay_d = delay_q; width_d = width_q;
    hd_d = hd_q; hw_d = hw_q; acnt_d = acnt_q; hit_d = hit_q;
    arm_d = 1'b0; rg_d = 1'b0; done_d = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = (state_q == ARM) || (state_q == SETTLE);
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      rg_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start && !abort) begin
          dmax_d = delay_max; dstep_d = delay_step;
          wmin_d = width_min; wmax_d = width_max; wstep_d = width_step;
          settle_d = settle_cycles; tmo_d = timeout_cycles; att_d = attempts;
          delay_d = delay_min; width_d = width_min; pp_d = '0;
          hit_d = 1'b0; hd_d = '0; hw_d = '0; acnt_d = '0;
          rg_d = 1'b1; state_d = RST_GL;
        end
        RST_GL: begin
          arm_d = 1'b1; tmr_load = 1'b1; state_d = ARM;
        end
        ARM: begin
          if (glitch_finished) begin
            tmr_load = 1'b1; state_d = SETTLE;
          end else if (tmo_q != '0 && tmr_match) begin
            state_d = STEP;
          end else begin
            arm_d = 1'b1;
          end
        end
        SETTLE: begin
          if (success_in) begin
            hit_d = 1'b1; hd_d = delay_q; hw_d = width_q;
            acnt_d = acnt_inc; done_d = 1'b1; state_d = DONE;
          end else if (tmr_match) begin
            state_d = STEP;
          end
        end
        STEP: begin
          acnt_d = acnt_inc;
          if (pp_nxt < {1'b0, att_eff}) begin
            pp_d = pp_nxt[AW-1:0]; rg_d = 1'b1; state_d = RST_GL;
          end else begin
            pp_d = '0;
            if (!w_wrap) begin
              width_d = wsum[W-1:0]; rg_d = 1'b1; state_d = RST_GL;
            end else begin
              width_d = wmin_q;
              if (!d_end) begin
                delay_d = dsum[W-1:0]; rg_d = 1'b1; state_d = RST_GL;
              end else begin
                done_d = 1'b1; state_d = DONE;
              end
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dmax_q <= '0; dstep_q <= '0; wmin_q <= '0; wmax_q <= '0; wstep_q <= '0;
      settle_q <= '0; tmo_q <= '0; att_q <= '0; pp_q <= '0;
      delay_q <= '0; width_q <= '0; hd_q <= '0; hw_q <= '0; acnt_q <= '0;
      hit_q <= 1'b0; arm_q <= 1'b0; rg_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dmax_q <= dmax_d; dstep_q <= dstep_d; wmin_q <= wmin_d; wmax_q <= wmax_d;
      wstep_q <= wstep_d; settle_q <= settle_d; tmo_q <= tmo_d; att_q <= att_d;
      pp_q <= pp_d; delay_q <= delay_d; width_q <= width_d;
      hd_q <= hd_d; hw_q <= hw_d; acnt_q <= acnt_d;
      hit_q <= hit_d; arm_q <= arm_d; rg_q <= rg_d; busy_q <= busy_d; done_q <= done_d;
    end
  end

  assign glitch_delay   = delay_q;
  assign glitch_width   = width_q;
  assign arm            = arm_q;
  assign reset_glitcher = rg_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign hit            = hit_q;
  assign hit_delay      = hd_q;
  assign hit_width      = hw_q;
  assign attempt_count  = acnt_q;
endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Scoreboard bench: stimulus queues expected points/done records, a monitor
// pops them on each arm rise and done pulse.
module tb_glitch_sweep_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [31:0] delay_min, delay_max, delay_step, width_min, width_max, width_step;
  logic [15:0] attempts;
  logic [31:0] settle_cycles, timeout_cycles;
  logic        glitch_finished, success_in;
  logic [31:0] glitch_delay, glitch_width, hit_delay, hit_width, attempt_count;
  logic        arm, reset_glitcher, busy, done, hit;

  logic        fin_en = 1'b0, succ_en = 1'b0;
  logic [31:0] sd = '0, sw = '0;
  int          n_tests = 0, n_fail = 0;
  logic [63:0]  exp_pt[$];
  logic [127:0] exp_done[$];
  int           exp_len[$];

  glitch_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .delay_min(delay_min), .delay_max(delay_max), .delay_step(delay_step),
    .width_min(width_min), .width_max(width_max), .width_step(width_step),
    .attempts(attempts), .settle_cycles(settle_cycles), .timeout_cycles(timeout_cycles),
    .glitch_finished(glitch_finished), .success_in(success_in),
    .glitch_delay(glitch_delay), .glitch_width(glitch_width),
    .arm(arm), .reset_glitcher(reset_glitcher), .busy(busy), .done(done), .hit(hit),
    .hit_delay(hit_delay), .hit_width(hit_width), .attempt_count(attempt_count)
  );

  always #5 clk = ~clk;

  // Target model: reports success only while settling at the chosen point.
  assign success_in = succ_en && (glitch_delay == sd) && (glitch_width == sw) && !arm;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Glitch engine model: finishes 3 cycles after arm rises.
  initial begin
    int eng_cnt;
    eng_cnt = 0;
    glitch_finished = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (fin_en && arm) begin
        eng_cnt++;
        glitch_finished = (eng_cnt == 3);
      end else begin
        eng_cnt = 0;
        glitch_finished = 1'b0;
      end
    end
  end

  initial begin
    logic arm_prev;
    int   arm_len;
    logic [63:0]  p;
    logic [127:0] d;
    int   l;
    arm_prev = 1'b0;
    arm_len  = 0;
    forever begin
      @(negedge clk);
      if (arm && !arm_prev) begin
        if (exp_pt.size() == 0) chk("point_unexpected", {glitch_delay, glitch_width}, 64'h0);
        else begin
          p = exp_pt.pop_front();
          chk("point", {glitch_delay, glitch_width}, p);
        end
      end
      if (!arm && arm_prev && exp_len.size() > 0) begin
        l = exp_len.pop_front();
        chk("arm_window", arm_len, l);
      end
      arm_len  = arm ? arm_len + 1 : 0;
      arm_prev = arm;
      if (done) begin
        if (exp_done.size() == 0) chk("done_unexpected", done, 1'b0);
        else begin
          d = exp_done.pop_front();
          chk("done_rec", {hit, hit_delay, hit_width, attempt_count}, d);
        end
      end
    end
  end

  task automatic cfg(input logic [31:0] dmin, dmax, dstp, wmin, wmax, wstp,
                     input logic [15:0] att, input logic [31:0] stl, tmo);
    delay_min = dmin; delay_max = dmax; delay_step = dstp;
    width_min = wmin; width_max = wmax; width_step = wstp;
    attempts = att; settle_cycles = stl; timeout_cycles = tmo;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 2000) begin tick(1); k++; end
    if (k >= 2000) chk({nm, "_timeout"}, busy, 1'b0);
    tick(2);
  endtask

  task automatic push_done(input logic h, input logic [31:0] d, w, a);
    exp_done.push_back({31'd0, h, d, w, a});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {arm, reset_glitcher, done, hit, attempt_count, glitch_delay}, '0);
    rst = 1'b0;
    tick(1);
    chk("idle_outs", {busy, arm, reset_glitcher, done}, '0);

    // Full 3x2 sweep, no hit; a start pulse mid-sweep must be ignored.
    cfg(10, 12, 1, 5, 6, 1, 1, 0, 0);
    fin_en = 1'b1;
    for (int dl = 10; dl <= 12; dl++)
      for (int wd = 5; wd <= 6; wd++) exp_pt.push_back({32'(dl), 32'(wd)});
    push_done(1'b0, 0, 0, 6);
    do_start();
    tick(15);
    delay_min = 99; width_max = 0; attempts = 5;
    do_start();
    cfg(10, 12, 1, 5, 6, 1, 1, 0, 0);
    wait_idle("sweep6");
    chk("sticky_count", attempt_count, 32'd6);

    // Hit at (11,6) after four attempts.
    sd = 11; sw = 6; succ_en = 1'b1;
    exp_pt.push_back({32'd10, 32'd5}); exp_pt.push_back({32'd10, 32'd6});
    exp_pt.push_back({32'd11, 32'd5}); exp_pt.push_back({32'd11, 32'd6});
    push_done(1'b1, 11, 6, 4);
    do_start();
    wait_idle("hit");
    succ_en = 1'b0;
    chk("hit_sticky", {hit, hit_delay, hit_width}, {1'b1, 32'd11, 32'd6});

    // Timeouts: three 20-cycle arm windows at a single point.
    cfg(7, 7, 1, 9, 9, 1, 3, 0, 20);
    fin_en = 1'b0;
    repeat (3) begin exp_pt.push_back({32'd7, 32'd9}); exp_len.push_back(20); end
    push_done(1'b0, 0, 0, 3);
    do_start();
    wait_idle("timeout");

    // Width sum overflows 32 bits; attempts=0 behaves as 1.
    cfg(3, 3, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 4, 0, 0, 0);
    fin_en = 1'b1;
    exp_pt.push_back({32'd3, 32'hFFFF_FFFE});
    push_done(1'b0, 0, 0, 1);
    do_start();
    wait_idle("wovf");

    // delay min>max and width step 0 collapse to one point.
    cfg(8, 2, 1, 4, 100, 0, 1, 0, 0);
    exp_pt.push_back({32'd8, 32'd4});
    push_done(1'b0, 0, 0, 1);
    do_start();
    wait_idle("degenerate");

    // Start latency and abort during ARM.
    cfg(1, 5, 1, 1, 5, 1, 1, 0, 0);
    fin_en = 1'b0;
    exp_pt.push_back({32'd1, 32'd1});
    do_start();
    chk("lat_rg", {reset_glitcher, arm, busy}, 3'b101);
    tick(1);
    chk("lat_arm", {reset_glitcher, arm}, 2'b01);
    tick(4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_outs", {arm, reset_glitcher, busy, done}, 4'b0100);
    tick(1);
    chk("abort_rg_off", {reset_glitcher, busy}, 2'b00);
    tick(3);

    // Reset mid-SETTLE of the second point.
    cfg(2, 3, 1, 7, 7, 1, 1, 10, 0);
    fin_en = 1'b1;
    exp_pt.push_back({32'd2, 32'd7}); exp_pt.push_back({32'd3, 32'd7});
    do_start();
    begin
      int falls, k;
      logic ap;
      falls = 0; k = 0; ap = arm;
      while (falls < 2 && k < 500) begin
        tick(1); k++;
        if (ap && !arm) falls++;
        ap = arm;
      end
      if (k >= 500) chk("settle_wait_timeout", falls, 2);
    end
    tick(2);
    chk("pre_rst_count", attempt_count, 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_ctl", {busy, arm, reset_glitcher, done, hit}, '0);
    chk("midrst_data", {glitch_delay, glitch_width, hit_delay, hit_width}, '0);
    chk("midrst_count", attempt_count, '0);
    tick(3);
    chk("midrst_idle", busy, 1'b0);

    chk("pt_queue_empty", exp_pt.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    chk("len_queue_empty", exp_len.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
